// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving the j/k inputs of a downstream JK flip-flop.
// Queues {op, rep} commands, replays each for rep+1 cycles, and checks q_in against an internal q model.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | nothing in flight, j=k=0; pops the FIFO head as soon as one exists
// S_DRIVE | replaying the loaded op on j/k until rem reaches zero
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [3:0]    cmd_rep,
  output logic          cmd_ready,
  input  logic          q_in,
  output logic          j,
  output logic          k,
  output logic          busy,
  output logic [AW:0]   level,
  output logic          q_exp,
  output logic          err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  state_t         r_state;
  state_t         w_state_nxt;

  logic [5:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_level;

  logic           r_j;
  logic           r_k;
  logic [3:0]     r_rem;
  logic           r_q_exp;
  logic           r_chk_en;
  logic           r_err;

  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic           w_full;
  logic [5:0]     w_head;
  logic           w_j_nxt;
  logic           w_k_nxt;
  logic [3:0]     w_rem_nxt;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LP_FULL);
  assign w_push    = cmd_valid && !w_full;
  assign w_head    = r_mem[r_rd_ptr];

  assign cmd_ready = !w_full;
  assign j         = r_j;
  assign k         = r_k;
  assign busy      = (r_state == S_DRIVE);
  assign level     = r_level;
  assign q_exp     = r_q_exp;
  assign err       = r_err;

  // FIFO storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_rep};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if ((r_rem == 4'd0) && w_empty) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop in DRIVE at rem==0 chains straight into the next command with no idle cycle.
  always_comb begin
    w_pop     = 1'b0;
    w_j_nxt   = r_j;
    w_k_nxt   = r_k;
    w_rem_nxt = r_rem;
    if (!w_empty && ((r_state == S_IDLE) || (r_rem == 4'd0))) begin
      w_pop     = 1'b1;
      w_j_nxt   = w_head[5];
      w_k_nxt   = w_head[4];
      w_rem_nxt = w_head[3:0];
    end else if ((r_state == S_DRIVE) && (r_rem != 4'd0)) begin
      w_rem_nxt = r_rem - 4'd1;
    end else begin
      w_j_nxt   = 1'b0;
      w_k_nxt   = 1'b0;
      w_rem_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_j   <= 1'b0;
      r_k   <= 1'b0;
      r_rem <= 4'd0;
    end else begin
      r_j   <= w_j_nxt;
      r_k   <= w_k_nxt;
      r_rem <= w_rem_nxt;
    end
  end

  // q model samples the same j/k the flip-flop sees at this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_exp  <= 1'b0;
      r_chk_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case ({r_j, r_k})
        2'b01:   r_q_exp <= 1'b0;
        2'b10:   r_q_exp <= 1'b1;
        2'b11:   r_q_exp <= ~r_q_exp;
        default: r_q_exp <= r_q_exp;
      endcase
      r_chk_en <= 1'b1;
      if (r_chk_en) begin
        r_err <= r_err | (q_in != r_q_exp);
      end
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: behavioural JK flip-flop downstream, j/k scoreboard,
// table of single commands plus hand sequences for burst, backpressure, mismatch and reset.
module tb_jk_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_rep;
  logic       cmd_ready;
  logic       q_in;
  logic       j;
  logic       k;
  logic       busy;
  logic [2:0] level;
  logic       q_exp;
  logic       err;

  logic       ff_q;
  logic       inj;

  int         n_checks;
  int         n_err;
  int         busy_cycles;
  int         falls;
  logic       prev_busy;
  logic [1:0] sb [$];

  typedef struct {
    logic [1:0] op;
    logic [3:0] rep;
    logic       exp_q;
  } vec_t;
  vec_t vecs [8];

  jk_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_rep   (cmd_rep),
    .cmd_ready (cmd_ready),
    .q_in      (q_in),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .level     (level),
    .q_exp     (q_exp),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream JK flip-flop with synchronous active-high reset driven by ~rst.
  always @(posedge clk) begin
    if (!rst) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end
  assign q_in = ff_q ^ inj;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then compare j/k with the scoreboard head while busy.
  task automatic tick();
    logic [1:0] e;
    @(posedge clk);
    #1;
    if (busy) begin
      busy_cycles++;
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow: busy with jk=%0d but nothing expected at %0t", {j, k}, $time);
      end else begin
        e = sb.pop_front();
        chk("jk_drive", int'({j, k}), int'(e));
      end
    end else begin
      chk("jk_idle", int'({j, k}), 0);
    end
    if (prev_busy && !busy) falls++;
    prev_busy = busy;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] rep);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rep   = rep;
    for (int i = 0; i <= int'(rep); i++) sb.push_back(op);
    while (!cmd_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!cmd_ready) chk("send_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   b0;
    int   f0;
    logic exp_t [4];

    vecs[0] = '{2'b01, 4'd1, 1'b0};
    vecs[1] = '{2'b11, 4'd0, 1'b1};
    vecs[2] = '{2'b00, 4'd2, 1'b1};
    vecs[3] = '{2'b11, 4'd2, 1'b0};
    vecs[4] = '{2'b10, 4'd3, 1'b1};
    vecs[5] = '{2'b11, 4'd1, 1'b1};
    vecs[6] = '{2'b00, 4'd0, 1'b1};
    vecs[7] = '{2'b01, 4'd0, 1'b0};
    exp_t[0] = 1'b0; exp_t[1] = 1'b1; exp_t[2] = 1'b0; exp_t[3] = 1'b1;

    n_checks = 0; n_err = 0; busy_cycles = 0; falls = 0; prev_busy = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rep = 4'd0; inj = 1'b0;
    rst = 1'b1;
    #2;
    reset_dut();

    chk("rst_j", int'(j), 0);
    chk("rst_k", int'(k), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_q_exp", int'(q_exp), 0);
    chk("rst_err", int'(err), 0);

    // single set, rep=0
    send(2'b10, 4'd0);
    tick();
    chk("set_j", int'(j), 1);
    chk("set_k", int'(k), 0);
    chk("set_busy", int'(busy), 1);
    chk("set_q_before", int'(q_exp), 0);
    tick();
    chk("set_busy_done", int'(busy), 0);
    chk("set_q_exp", int'(q_exp), 1);
    chk("set_q_in", int'(q_in), 1);

    // set then toggle x4 back-to-back
    send(2'b10, 4'd0);
    send(2'b11, 4'd3);
    tick();
    chk("burst_q_set", int'(q_exp), 1);
    chk("burst_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_q_in", int'(q_in), int'(exp_t[i]));
      chk("burst_q_exp", int'(q_exp), int'(exp_t[i]));
      chk("burst_err", int'(err), 0);
    end
    chk("burst_idle", int'(busy), 0);

    for (int v = 0; v < 8; v++) begin
      send(vecs[v].op, vecs[v].rep);
      tick();
      cnt = 0;
      while (busy && cnt < 40) begin
        cnt++;
        tick();
      end
      chk("vec_len", cnt, int'(vecs[v].rep) + 1);
      chk("vec_q_exp", int'(q_exp), int'(vecs[v].exp_q));
      chk("vec_q_in", int'(q_in), int'(vecs[v].exp_q));
      chk("vec_err", int'(err), 0);
    end

    // fill and backpressure: one long clear, then five more
    b0 = busy_cycles;
    f0 = falls;
    send(2'b01, 4'd15);
    send(2'b10, 4'd2);
    send(2'b11, 4'd1);
    send(2'b00, 4'd0);
    send(2'b11, 4'd3);
    chk("fill_level", int'(level), 4);
    chk("fill_ready", int'(cmd_ready), 0);
    send(2'b10, 4'd1);
    cnt = 0;
    while (busy && cnt < 60) begin
      cnt++;
      tick();
    end
    chk("fill_busy_cycles", busy_cycles - b0, 28);
    chk("fill_no_gap", falls - f0, 1);
    chk("fill_sb_empty", sb.size(), 0);
    chk("fill_q_exp", int'(q_exp), 1);
    chk("fill_err", int'(err), 0);
    chk("fill_level_end", int'(level), 0);

    // one-cycle mismatch on q_in while q_exp=1
    chk("mm_err_before", int'(err), 0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("mm_err_set", int'(err), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mm_err_sticky", int'(err), 1);
    end
    rst = 1'b0;
    #1;
    chk("mm_err_rst", int'(err), 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tick();
    chk("mm_err_after", int'(err), 0);

    // reset during a long toggle with two entries queued
    send(2'b11, 4'd10);
    tick();
    send(2'b10, 4'd1);
    send(2'b01, 4'd0);
    chk("mid_level_q", int'(level), 2);
    tick();
    tick();
    chk("mid_busy_pre", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_j", int'(j), 0);
    chk("mid_k", int'(k), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_level", int'(level), 0);
    sb.delete();
    repeat (3) tick();
    rst = 1'b1;
    b0 = busy_cycles;
    repeat (15) tick();
    chk("mid_no_drive", busy_cycles - b0, 0);
    chk("mid_level_after", int'(level), 0);
    chk("mid_ready_after", int'(cmd_ready), 1);
    chk("mid_err_after", int'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
